// File: rtl/nf10_arb_pkg.sv
// Shared types and the round-robin search used by the nf10 input arbiter.
package nf10_arb_pkg;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} arb_state_t;

    localparam int SRC_PORT_W = 8;
    localparam int MAX_INPUTS = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } sel_t;

    // First non-empty input after cur, wrapping; cur itself is tried last.
    function automatic sel_t next_sel(input logic [MAX_INPUTS-1:0] empty_vec,
                                      input logic [2:0] cur, input int n);
        sel_t       r;
        logic [2:0] i3;
        r = '0;
        for (int k = n; k >= 1; k--) begin
            i3 = 3'((int'(cur) + k) % n);
            if (!empty_vec[i3]) begin
                r.found = 1'b1;
                r.idx   = i3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: head entry is visible on dout while not empty.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] NF_LVL = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0]   cnt;
    logic                      push, pop;

    assign empty       = (cnt == '0);
    assign nearly_full = (cnt >= NF_LVL);
    assign push        = wr_en & ~cnt[MAX_DEPTH_BITS];
    assign pop         = rd_en & ~empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/nf10_input_arbiter_rr.sv
// Packet-granular round-robin AXI-Stream merge of NUM_INPUTS buffered inputs.
// Optional ARB_SRC_PORT_STAMP_EN overwrites the TUSER source-port field with the granted input.
module nf10_input_arbiter_rr
    import nf10_arb_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_INPUTS           = 5,
    parameter int SRC_PORT_POS         = 16,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                                            AXI_ACLK,
    input  logic                                            AXI_RESET,
    input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
    input  logic [NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
    input  logic [NUM_INPUTS-1:0]                           S_AXIS_TVALID,
    output logic [NUM_INPUTS-1:0]                           S_AXIS_TREADY,
    input  logic [NUM_INPUTS-1:0]                           S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]                  M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]                 M_AXIS_TUSER,
    output logic                                            M_AXIS_TVALID,
    input  logic                                            M_AXIS_TREADY,
    output logic                                            M_AXIS_TLAST
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int FW = 1 + UW + SW + DW;

    if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH || C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH ||
        NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS || SRC_PORT_POS + SRC_PORT_W > UW) begin : g_bad_cfg
        $error("nf10_input_arbiter_rr: unsupported parameter set");
    end

    logic [NUM_INPUTS-1:0][FW-1:0] fifo_dout;
    logic [NUM_INPUTS-1:0]         empty, nearly_full, rd_en;
    logic [MAX_INPUTS-1:0]         empty_ext;
    arb_state_t                    state, next_state;
    logic [2:0]                    cur, next_cur, grant, next_grant, sel, out_idx, hold_sel;
    logic                          hold_q, m_valid, pop;
    sel_t                          search;
    logic [FW-1:0]                 head;
    logic                          head_last;

    assign S_AXIS_TREADY = ~nearly_full & {NUM_INPUTS{~AXI_RESET}};

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign rd_en[i] = pop & (out_idx == 3'(i));

        fallthrough_small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
            .clk        (AXI_ACLK),
            .rst        (AXI_RESET),
            .din        ({S_AXIS_TLAST[i], S_AXIS_TUSER[i*UW +: UW],
                          S_AXIS_TSTRB[i*SW +: SW], S_AXIS_TDATA[i*DW +: DW]}),
            .wr_en      (S_AXIS_TVALID[i] & S_AXIS_TREADY[i]),
            .rd_en      (rd_en[i]),
            .dout       (fifo_dout[i]),
            .nearly_full(nearly_full[i]),
            .empty      (empty[i])
        );
    end

    // A selection offered while the master stalls is held, so a newly filled
    // higher-priority input cannot swap the head under TVALID.
    always_comb begin
        empty_ext                 = '1;
        empty_ext[NUM_INPUTS-1:0] = empty;
        search                    = next_sel(empty_ext, cur, NUM_INPUTS);
        sel                       = hold_q ? hold_sel : search.idx;
        out_idx                   = sel;
        m_valid                   = hold_q | search.found;
        if (state == PKT) begin
            out_idx = grant;
            m_valid = !empty[grant];
        end
    end

    assign head      = fifo_dout[out_idx];
    assign head_last = head[FW-1];
    assign pop       = m_valid & M_AXIS_TREADY;

    always_comb begin
        next_state = state;
        next_cur   = cur;
        next_grant = grant;
        case (state)
            IDLE: if (pop) begin
                next_grant = sel;
                if (head_last) next_cur = sel;
                else           next_state = PKT;
            end
            PKT: if (pop && head_last) begin
                next_state = IDLE;
                next_cur   = grant;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state    <= IDLE;
            cur      <= 3'(NUM_INPUTS - 1);
            grant    <= '0;
            hold_q   <= 1'b0;
            hold_sel <= '0;
        end else begin
            state    <= next_state;
            cur      <= next_cur;
            grant    <= next_grant;
            hold_q   <= (state == IDLE) & m_valid & ~M_AXIS_TREADY;
            hold_sel <= sel;
        end
    end

    assign M_AXIS_TVALID = m_valid;

    always_comb begin
        {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = m_valid ? head : '0;
`ifdef ARB_SRC_PORT_STAMP_EN
        if (m_valid) M_AXIS_TUSER[SRC_PORT_POS +: SRC_PORT_W] = 8'd1 << out_idx;
`endif
    end

endmodule

// File: doc/nf10_input_arbiter_rr.md
# nf10_input_arbiter_rr

Round-robin, packet-granular AXI-Stream arbiter that merges NUM_INPUTS receive streams (MAC and DMA queues) into the single stream consumed by the router output port lookup stage. Each input is buffered in a small fall-through FIFO. A whole packet is forwarded from one input before the grant moves on, so packets are never interleaved on the master port. TDATA, TSTRB and TUSER are carried through unchanged unless source-port stamping is compiled in.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master TDATA width
- C_S_AXIS_DATA_WIDTH, 256, slave TDATA width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width; must equal C_M_AXIS_TUSER_WIDTH
- NUM_INPUTS, 5, number of slave streams, 2..8
- SRC_PORT_POS, 16, LSB of the 8-bit one-hot source-port field in TUSER
- FIFO_DEPTH_BITS, 2, log2 of per-input FIFO depth

Ports:
- AXI_ACLK, input, 1, sole clock
- AXI_RESET, input, 1, reset; asynchronous, active-high
- S_AXIS_TDATA, input, NUM_INPUTS*C_S_AXIS_DATA_WIDTH, input i occupies slice i
- S_AXIS_TSTRB, input, NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8, per-input byte strobes
- S_AXIS_TUSER, input, NUM_INPUTS*C_S_AXIS_TUSER_WIDTH, per-input sideband
- S_AXIS_TVALID, input, NUM_INPUTS, per-input valid
- S_AXIS_TREADY, output, NUM_INPUTS, per-input ready
- S_AXIS_TLAST, input, NUM_INPUTS, per-input end of packet
- M_AXIS_TDATA, output, C_M_AXIS_DATA_WIDTH, merged data
- M_AXIS_TSTRB, output, C_M_AXIS_DATA_WIDTH/8, merged strobes
- M_AXIS_TUSER, output, C_M_AXIS_TUSER_WIDTH, merged sideband
- M_AXIS_TVALID, output, 1, merged valid
- M_AXIS_TREADY, input, 1, downstream ready
- M_AXIS_TLAST, output, 1, merged end of packet

## Operation
- Per-input FIFO:
  - Stores {TLAST, TUSER, TSTRB, TDATA}.
  - Write enable is S_AXIS_TVALID[i] & S_AXIS_TREADY[i].
  - S_AXIS_TREADY[i] = !nearly_full[i] & !AXI_RESET.
- State machine, two states:
  - IDLE: search inputs cur+1, cur+2, … (mod NUM_INPUTS) for the first non-empty FIFO; that input becomes `sel`. If none is found, M_AXIS_TVALID = 0. If one is found, drive its FIFO head on M_AXIS_* with TVALID = 1. On M_AXIS_TREADY: pop that FIFO and latch grant = sel. If the popped beat has TLAST, stay in IDLE and set cur = sel; otherwise go to PKT.
  - PKT: output is locked to `grant`. M_AXIS_TVALID = !empty[grant]. Pop on TVALID & TREADY. On a popped TLAST beat: go to IDLE, set cur = grant.
- Fairness:
  - An input that has just completed a packet has the lowest priority in the next search.
  - Any input with a pending packet is served within NUM_INPUTS−1 packets.
- While locked in PKT, an empty granted FIFO stalls the output (TVALID low). Other inputs are not served.
- Pushes and pops on the same FIFO in the same cycle are both honoured; occupancy is unchanged.
- Master outputs are combinational from the FIFO head and the select logic. There is no output register.

## Timing
- Reset values:
  - state = IDLE, cur = NUM_INPUTS−1 (so input 0 wins first), all FIFOs empty.
  - M_AXIS_TVALID = 0; M_AXIS_TDATA/TSTRB/TUSER/TLAST = 0 while empty.
  - S_AXIS_TREADY = 0 while AXI_RESET is high.
- Latency: a slave beat accepted in cycle t appears on the master port in cycle t+1 at the earliest.
- Throughput: one beat per cycle while the granted FIFO is non-empty and M_AXIS_TREADY is high.
- Back-to-back packets from different inputs need no idle cycle. A TLAST pop and the next selection occur on consecutive cycles.
- nearly_full asserts at 2^FIFO_DEPTH_BITS − 1 entries.
- Data stability: while TVALID is high and TREADY is low, all M_AXIS_* signals hold stable and `sel` does not change. In IDLE, the selection is frozen once TVALID is high.
- Reset mid-packet: all FIFO contents are discarded and the block returns to IDLE. Partial packets are lost and the remainder is not emitted.

## Configuration
- ARB_SRC_PORT_STAMP_EN:
  - Defined: M_AXIS_TUSER[SRC_PORT_POS+7:SRC_PORT_POS] is overwritten with the one-hot value (1 << granted input index). All other TUSER bits pass through.
  - Undefined: TUSER passes through unmodified.

## Structure
- Shared package nf10_arb_pkg:
  - localparams IDLE/PKT.
  - The search function next_sel(empty_vec, cur).
  - SRC_PORT field width constant (8).
- Per-input buffering: NUM_INPUTS instances of the existing fallthrough_small_fifo, generated in a loop.
- No other sub-module; arbitration and muxing stay in the top.

## Test plan
- Single input: 3-beat packet on input 2 (TDATA 0xA1, 0xA2, 0xA3) with M_AXIS_TREADY = 1 → same 3 beats on the master port starting the cycle after the first accept; TLAST on beat 3; TUSER unchanged (stamp off).
- Fairness: inputs 0, 1, 4 each hold two 1-beat packets at reset release → master order 0, 1, 4, 0, 1, 4.
- No interleave: input 0 sends a 4-beat packet with 2-cycle gaps between beats while input 1 is full → no input-1 beat appears until input 0's TLAST is popped.
- Backpressure: M_AXIS_TREADY held low 10 cycles mid-packet → master outputs stable; S_AXIS_TREADY[i] drops once 3 entries are queued; no beat lost or duplicated.
- Stamp (ARB_SRC_PORT_STAMP_EN defined): packet from input 3 with TUSER[23:16] = 0x00 → output TUSER[23:16] = 0x08.
- Reset mid-packet: assert AXI_RESET after beat 2 of 5 → M_AXIS_TVALID = 0 immediately; after release, a new packet on input 0 is forwarded first with no stale beats.
